// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: ROB geometry, register index widths and the ROB entry layout.
// Reservation station reuses TAG_W for its tag fields.
package ooo_pkg;
  localparam int ROB_SIZE = 64;
  localparam int TAG_W    = $clog2(ROB_SIZE);
  localparam int PREG_W   = 6;
  localparam int AREG_W   = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_rd;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] preg_old;
    logic [31:0]       data;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: one dispatch per cycle, three writeback ports, in-order retire of up to two.
// All outputs are combinational from registered state only; dispatch is refused while full.
module reorder_buffer
  import ooo_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disp_valid,
  input  logic                        disp_has_rd,
  input  logic [AREG_W-1:0]           disp_areg,
  input  logic [PREG_W-1:0]           disp_preg,
  input  logic [PREG_W-1:0]           disp_preg_old,
  output logic                        disp_ready,
  output logic [TAG_W-1:0]            disp_tag,
  input  logic [2:0]                  wb_valid,
  input  logic [2:0][TAG_W-1:0]       wb_tag,
  input  logic [2:0][31:0]            wb_data,
  output logic [1:0]                  ret_valid,
  output logic [1:0]                  ret_has_rd,
  output logic [1:0][AREG_W-1:0]      ret_areg,
  output logic [1:0][PREG_W-1:0]      ret_preg,
  output logic [1:0][31:0]            ret_data,
  output logic [1:0]                  free_valid,
  output logic [1:0][PREG_W-1:0]      free_preg,
  output logic [TAG_W:0]              count,
  output logic                        empty
);

  rob_entry_t       r_rob [ROB_SIZE];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic [TAG_W-1:0] w_head1;
  rob_entry_t       w_slot0;
  rob_entry_t       w_slot1;
  logic             w_ret0;
  logic             w_ret1;
  logic             w_accept;
  logic [1:0]       w_nret;

  assign w_head1  = r_head + TAG_W'(1);
  assign w_slot0  = r_rob[r_head];
  assign w_slot1  = r_rob[w_head1];
  assign w_ret0   = w_slot0.valid && w_slot0.done;
  assign w_ret1   = w_ret0 && w_slot1.valid && w_slot1.done;
  assign w_nret   = {1'b0, w_ret0} + {1'b0, w_ret1};
  assign w_accept = disp_valid && disp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) r_rob[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Ascending port order so the highest port wins on a shared tag.
      for (int p = 0; p < 3; p++) begin
        if (wb_valid[p] && r_rob[wb_tag[p]].valid) begin
          r_rob[wb_tag[p]].done <= 1'b1;
          r_rob[wb_tag[p]].data <= wb_data[p];
        end
      end
      if (w_ret0) r_rob[r_head]  <= '0;
      if (w_ret1) r_rob[w_head1] <= '0;
      // Tail never aliases a retiring slot: that needs empty (no retire) or full (no accept).
      if (w_accept) begin
        r_rob[r_tail] <= '{valid: 1'b1, done: 1'b0, has_rd: disp_has_rd,
                           areg: disp_areg, preg: disp_preg,
                           preg_old: disp_preg_old, data: 32'h0};
      end
      r_tail  <= r_tail + TAG_W'(w_accept);
      r_head  <= r_head + TAG_W'(w_nret);
      r_count <= r_count + (TAG_W+1)'(w_accept) - (TAG_W+1)'(w_nret);
    end
  end

  assign disp_ready = (r_count != (TAG_W+1)'(ROB_SIZE));
  assign disp_tag   = r_tail;
  assign count      = r_count;
  assign empty      = (r_count == '0);

  assign ret_valid  = {w_ret1, w_ret0};
  assign ret_has_rd = {w_ret1 && w_slot1.has_rd, w_ret0 && w_slot0.has_rd};
  assign ret_areg   = {w_slot1.areg, w_slot0.areg};
  assign ret_preg   = {w_slot1.preg, w_slot0.preg};
  assign ret_data   = {w_slot1.data, w_slot0.data};
  assign free_valid = ret_has_rd;
  assign free_preg  = {w_slot1.preg_old, w_slot0.preg_old};

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a program-order queue model checked every cycle, plus literal spot checks.
module tb_reorder_buffer;
  import ooo_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   d_valid, d_has_rd;
  logic [AREG_W-1:0]      d_areg;
  logic [PREG_W-1:0]      d_preg, d_preg_old;
  logic                   disp_ready;
  logic [TAG_W-1:0]       disp_tag;
  logic [2:0]             wb_v;
  logic [2:0][TAG_W-1:0]  wb_t;
  logic [2:0][31:0]       wb_d;
  logic [1:0]             ret_valid, ret_has_rd, free_valid;
  logic [1:0][AREG_W-1:0] ret_areg;
  logic [1:0][PREG_W-1:0] ret_preg, free_preg;
  logic [1:0][31:0]       ret_data;
  logic [TAG_W:0]         count;
  logic                   empty;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .disp_valid(d_valid), .disp_has_rd(d_has_rd), .disp_areg(d_areg),
    .disp_preg(d_preg), .disp_preg_old(d_preg_old),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb_valid(wb_v), .wb_tag(wb_t), .wb_data(wb_d),
    .ret_valid(ret_valid), .ret_has_rd(ret_has_rd), .ret_areg(ret_areg),
    .ret_preg(ret_preg), .ret_data(ret_data),
    .free_valid(free_valid), .free_preg(free_preg),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          has_rd;
    int          areg;
    int          preg;
    int          preg_old;
    logic [31:0] data;
    bit          done;
  } m_t;

  m_t mq[$];
  int m_next_tag = 0;
  int serial = 0;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int max_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ret(input int k);
    if (mq.size() <= k) return 1'b0;
    if (k == 1 && !(mq[0].done)) return 1'b0;
    return mq[k].done;
  endfunction

  // Per-cycle comparison against the program-order queue.
  always @(negedge clk) begin
    if (chk_en) begin
      check("disp_ready", 64'(disp_ready), 64'(mq.size() < ROB_SIZE));
      check("disp_tag", 64'(disp_tag), 64'(m_next_tag));
      check("count", 64'(count), 64'(mq.size()));
      check("empty", 64'(empty), 64'(mq.size() == 0));
      if (int'(count) > max_count) max_count = int'(count);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ret_valid%0d", k), 64'(ret_valid[k]), 64'(m_ret(k)));
        if (m_ret(k)) begin
          check($sformatf("ret_has_rd%0d", k), 64'(ret_has_rd[k]), 64'(mq[k].has_rd));
          check($sformatf("ret_areg%0d", k), 64'(ret_areg[k]), 64'(mq[k].areg));
          check($sformatf("ret_preg%0d", k), 64'(ret_preg[k]), 64'(mq[k].preg));
          check($sformatf("ret_data%0d", k), 64'(ret_data[k]), 64'(mq[k].data));
          check($sformatf("free_valid%0d", k), 64'(free_valid[k]), 64'(mq[k].has_rd));
          if (mq[k].has_rd)
            check($sformatf("free_preg%0d", k), 64'(free_preg[k]), 64'(mq[k].preg_old));
        end else begin
          check($sformatf("free_valid%0d", k), 64'(free_valid[k]), 64'd0);
        end
      end
    end
  end

  task automatic idle_inputs();
    rst = 1'b0; d_valid = 1'b0; d_has_rd = 1'b0;
    d_areg = '0; d_preg = '0; d_preg_old = '0;
    wb_v = '0; wb_t = '0; wb_d = '0;
  endtask

  task automatic set_disp(input bit has_rd);
    d_valid    = 1'b1;
    d_has_rd   = has_rd;
    d_areg     = AREG_W'(serial % 32);
    d_preg     = PREG_W'(serial % 64);
    d_preg_old = PREG_W'((serial + 17) % 64);
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] data);
    wb_v[p] = 1'b1;
    wb_t[p] = TAG_W'(tag);
    wb_d[p] = data;
  endtask

  // One clock edge: advance the model from pre-edge state and driven inputs, then release inputs.
  task automatic tick();
    int  nret;
    bit  acc;
    m_t  e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_next_tag = 0;
    end else begin
      nret = int'(m_ret(0)) + int'(m_ret(1));
      acc  = d_valid && (mq.size() < ROB_SIZE);
      for (int p = 0; p < 3; p++)
        if (wb_v[p])
          foreach (mq[j])
            if (mq[j].tag == int'(wb_t[p])) begin
              mq[j].done = 1'b1;
              mq[j].data = wb_d[p];
            end
      repeat (nret) void'(mq.pop_front());
      if (acc) begin
        e.tag = m_next_tag; e.has_rd = d_has_rd; e.areg = int'(d_areg);
        e.preg = int'(d_preg); e.preg_old = int'(d_preg_old);
        e.data = 32'h0; e.done = 1'b0;
        mq.push_back(e);
        m_next_tag = (m_next_tag + 1) % ROB_SIZE;
        serial++;
      end
    end
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    serial = 0;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    chk_en = 1'b1;

    // Reset state.
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ready", 64'(disp_ready), 64'd1);
    check("rst_tag", 64'(disp_tag), 64'd0);
    check("rst_ret", 64'(ret_valid), 64'd0);
    tick();

    // Out-of-order completion, in-order retire.
    repeat (3) begin set_disp(1'b1); tick(); end
    set_wb(0, 2, 32'h2222_0002); tick();
    check("ooo_ret_none", 64'(ret_valid), 64'd0);
    set_wb(1, 0, 32'h0000_0a0a); tick();
    check("ooo_ret_tag0", 64'(ret_valid), 64'b01);
    tick();
    check("ooo_wait_tag1", 64'(ret_valid), 64'd0);
    set_wb(2, 1, 32'h1111_0001); tick();
    check("ooo_ret_both", 64'(ret_valid), 64'b11);
    check("ooo_preg0", 64'(ret_preg[0]), 64'd1);
    check("ooo_preg1", 64'(ret_preg[1]), 64'd2);
    check("ooo_data1", 64'(ret_data[1]), 64'h2222_0002);
    tick();
    check("ooo_drained", 64'(count), 64'd0);

    // Fill to 64, dual retire from full.
    do_reset();
    repeat (64) begin set_disp(1'b1); tick(); end
    check("full_count", 64'(count), 64'd64);
    check("full_ready", 64'(disp_ready), 64'd0);
    check("full_tag", 64'(disp_tag), 64'd0);
    set_disp(1'b1);
    set_wb(0, 0, 32'hdead_0000);
    set_wb(1, 1, 32'hdead_0001);
    tick();
    check("full_ret", 64'(ret_valid), 64'b11);
    check("full_free0", 64'(free_preg[0]), 64'd17);
    check("full_free1", 64'(free_preg[1]), 64'd18);
    check("full_still_closed", 64'(disp_ready), 64'd0);
    set_disp(1'b1);
    tick();
    check("full_reopen", 64'(disp_ready), 64'd1);
    check("full_count62", 64'(count), 64'd62);

    // Wrap with steady dispatch and retire; one cycle has two ports on the same tag.
    do_reset();
    for (int c = 0; c < 70; c++) begin
      if (c == 63) check("wrap_tag63", 64'(disp_tag), 64'd63);
      if (c == 64) check("wrap_tag0", 64'(disp_tag), 64'd0);
      set_disp(1'b1);
      if (c >= 1) set_wb(0, (c - 1) % 64, $urandom);
      if (c == 10) set_wb(2, 9, 32'hbeef_0009);
      tick();
    end
    check("wrap_max_count", 64'(max_count <= 64), 64'd1);

    // Store at head.
    do_reset();
    set_disp(1'b0); tick();
    set_wb(0, 0, 32'h5);
    tick();
    check("store_ret", 64'(ret_valid[0]), 64'd1);
    check("store_free", 64'(free_valid[0]), 64'd0);
    tick();

    // Reset with pending entries and writebacks in flight.
    do_reset();
    repeat (5) begin set_disp(1'b1); tick(); end
    rst = 1'b1;
    set_wb(0, 0, 32'h1); set_wb(1, 1, 32'h2); set_wb(2, 2, 32'h3);
    tick();
    serial = 0;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_ret", 64'(ret_valid), 64'd0);
    set_wb(0, 3, 32'h33); tick();
    check("stale_count", 64'(count), 64'd0);
    set_disp(1'b1); tick();
    check("stale_not_done", 64'(ret_valid), 64'd0);
    set_wb(1, 0, 32'h77); tick();
    check("post_rst_ret", 64'(ret_valid), 64'b01);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular 64-entry reorder buffer for the out-of-order core. Receives one renamed instruction per cycle from dispatch (alongside the reservation station write), allocates its tag, records completions from the three functional-unit writeback ports, and retires up to two completed instructions per cycle in program order. On retirement it publishes the architectural register update and the old physical register to return to the free list.

## Interface
- ROB_SIZE, 64, entry count (power of two); tag width TAG_W = log2(ROB_SIZE) = 6
- PREG_W, 6, physical register index width
- AREG_W, 5, architectural register index width
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- disp_valid  in  1  dispatch request this cycle
- disp_has_rd  in  1  instruction writes a register (0 for stores/branches)
- disp_areg  in  AREG_W  architectural destination
- disp_preg  in  PREG_W  new physical destination (rd)
- disp_preg_old  in  PREG_W  previous mapping of areg (rd_old)
- disp_ready  out  1  !full; dispatch accepted when disp_valid && disp_ready
- disp_tag  out  TAG_W  tag assigned to the accepted instruction (= tail)
- wb_valid  in  3  per-port completion strobe
- wb_tag  in  3×TAG_W  per-port completing tag
- wb_data  in  3×32  per-port result
- ret_valid  out  2  retirement slot k fires this cycle
- ret_has_rd  out  2  slot k updates a register
- ret_areg  out  2×AREG_W  architectural destination
- ret_preg  out  2×PREG_W  physical register now committed
- ret_data  out  2×32  committed value
- free_valid  out  2  slot k frees a physical register (= ret_valid[k] && ret_has_rd[k])
- free_preg  out  2×PREG_W  preg_old to return to free list
- count  out  TAG_W+1  occupancy, 0..ROB_SIZE
- empty  out  1  count == 0

## Operation
- Entry fields: valid, done, has_rd, areg, preg, preg_old, data[31:0].
- State: head, tail (TAG_W, wrap modulo ROB_SIZE), count (TAG_W+1).
- Dispatch: on accept, entry[tail] ← {valid=1, done=0, fields}; tail+1 (63→0 wraps).
- Completion: each wb port with wb_valid and entry[wb_tag].valid sets done=1, writes data. Strobe to a non-valid entry ignored. Same tag on two ports: higher port index's data wins.
- Retire slot 0: ret_valid[0] = entry[head].valid && done.
- Retire slot 1: ret_valid[1] = ret_valid[0] && entry[head+1].valid && done (never skips slot 0; head+1 wraps).
- On edge: retiring entries cleared (valid=0, done=0); head += number retired.
- count next = count + accepted − retired (0, 1 or 2).

## Timing
- Reset: head=tail=count=0, all valid/done=0; thus ret_valid=0, free_valid=0, disp_ready=1, empty=1, disp_tag=0.
- disp_ready, disp_tag, ret_*, free_*, count, empty: combinational from registered state; no input-to-output paths.
- Dispatch→visible in count: next cycle. Completion at edge N → retire earliest at edge N+1 (ret_valid high in cycle after completion).
- Dispatch-to-retire minimum latency: 2 edges (dispatch N, wb N+1, retire N+2).
- Full (count=64): disp_ready=0 even if retiring same cycle; reopens next cycle.
- Empty: ret_valid=0; dispatch and completion of the same tag in one cycle not possible (entry not yet valid) — completion dropped.
- Simultaneous dispatch and retire allowed whenever not full; count updates net.
- rst mid-operation: all entries discarded that edge; wb strobes during rst ignored.

## Structure
- Shared package ooo_pkg: ROB_SIZE, TAG_W, PREG_W, AREG_W, rob_entry_t struct; reused by the reservation station for tag fields.
- Single module; no sub-module needed (retire selection is two-slot combinational logic inside).

## Test plan
- Reset then idle: rst 1 cycle → count=0, empty=1, disp_ready=1, disp_tag=0, ret_valid=00.
- Dispatch tags 0,1,2; wb tag2 then tag0 → cycle after tag0 wb, ret_valid=01 (tag0 only); tag2 retires only after tag1 wb, with tag1 in same cycle (ret_valid=11).
- Fill 64 entries → disp_ready=0, count=64; wb tag 0 and 1 same cycle → next cycle ret_valid=11, free_preg = their preg_old; disp_ready=1 one cycle later.
- Wrap: cycle 70 dispatches with steady retire → disp_tag goes 63→0, retirement order preserved, count never exceeds 64.
- Store (has_rd=0) at head, done → ret_valid[0]=1, free_valid[0]=0.
- Assert rst with 5 entries pending and wb_valid=111 → next cycle count=0, ret_valid=00; stale wb to tag 3 afterwards has no effect.
